// File: rtl/mem_pkg.sv
// Shared constants for the req/addr_ok/data_ok memory protocol: data width,
// byte-lane count and the fixed response latency.
package mem_pkg;

  localparam int XLEN         = 32;
  localparam int NB_LANES     = XLEN / 8;
  localparam int RESP_LATENCY = 1;

  typedef logic [XLEN-1:0]     word_t;
  typedef logic [NB_LANES-1:0] strb_t;

endpackage

// File: rtl/iram_responder_sram.sv
// Single-port synchronous DEPTH x XLEN array with per-byte write enables
// and a registered read port.
module sram_1rw_be
  import mem_pkg::*;
#(
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  strb_t         be_i,
  input  word_t         wdata_i,
  output word_t         rdata_o
);

  word_t mem [DEPTH];
  word_t rdata_q;

  // Read and write share one port; a write leaves the read register untouched.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < NB_LANES; i++) begin
          if (be_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iram_responder.sv
// Memory-side responder: one request per cycle, response one cycle after acceptance.
// Optional wait states before each acceptance are built when IRAM_WAIT_STATE_EN is defined.
module iram_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 4096,
  parameter     INIT_FILE   = "",
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            iram_req,
  input  logic            iram_write,
  input  logic [NB_LANES-1:0] iram_wstrb,
  input  logic [XLEN-1:0] iram_addr,
  input  logic [XLEN-1:0] iram_wdata,
  output logic            iram_addr_ok,
  output logic            iram_data_ok,
  output logic [XLEN-1:0] iram_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic          accept;
  logic [AW-1:0] word_idx;
  word_t         sram_rdata;
  logic          data_ok_q, data_ok_d;
  logic          resp_rd_q, resp_rd_d;
  word_t         hold_q;

  // Byte offset and bits above the array are dropped, so addresses wrap.
  assign word_idx = iram_addr[AW+1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iram_addr[XLEN-1:AW+2], iram_addr[1:0]};

`ifdef IRAM_WAIT_STATE_EN
  localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [WCW-1:0] wcnt_q, wcnt_d;

  assign iram_addr_ok = (wcnt_q == WCW'(WAIT_CYCLES));

  // Dropping req restarts the stall from zero.
  always_comb begin
    wcnt_d = '0;
    if (iram_req && !iram_addr_ok) wcnt_d = wcnt_q + WCW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`else
  assign iram_addr_ok = 1'b1;
`endif

  assign accept = iram_req & iram_addr_ok;

  always_comb begin
    data_ok_d = accept;
    resp_rd_d = accept & ~iram_write;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      data_ok_q <= 1'b0;
      resp_rd_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      data_ok_q <= data_ok_d;
      resp_rd_q <= resp_rd_d;
      hold_q    <= iram_rdata;
    end
  end

  // Array access is gated by reset so a write seen during reset is discarded.
  sram_1rw_be #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_sram (
    .clk    (clk),
    .en_i   (accept & rst_b),
    .we_i   (iram_write),
    .addr_i (word_idx),
    .be_i   (iram_wstrb),
    .wdata_i(iram_wdata),
    .rdata_o(sram_rdata)
  );

  assign iram_data_ok = data_ok_q;
  assign iram_rdata   = resp_rd_q ? sram_rdata : hold_q;

endmodule

// File: tb/tb_iram_responder.sv
// Directed, table-driven bench for iram_responder; the wait-state sequences
// run only when IRAM_WAIT_STATE_EN is defined.
module tb_iram_responder;

`ifdef IRAM_WAIT_STATE_EN
  localparam int TB_WAIT = 2;
`else
  localparam int TB_WAIT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic        iram_req;
  logic        iram_write;
  logic [3:0]  iram_wstrb;
  logic [31:0] iram_addr;
  logic [31:0] iram_wdata;
  logic        iram_addr_ok;
  logic        iram_data_ok;
  logic [31:0] iram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iram_responder #(
    .DEPTH      (4096),
    .INIT_FILE  (""),
    .WAIT_CYCLES(TB_WAIT)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .iram_req    (iram_req),
    .iram_write  (iram_write),
    .iram_wstrb  (iram_wstrb),
    .iram_addr   (iram_addr),
    .iram_wdata  (iram_wdata),
    .iram_addr_ok(iram_addr_ok),
    .iram_data_ok(iram_data_ok),
    .iram_rdata  (iram_rdata)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_dok;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive at negedge, check addr_ok before the edge, response #1 after it.
  task automatic step(input string name, input logic rst, input logic req, input logic wr,
                      input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_aok, input logic exp_dok,
                      input logic chk_rd, input logic [31:0] exp_rd);
    @(negedge clk);
    rst_b = rst; iram_req = req; iram_write = wr; iram_wstrb = strb;
    iram_addr = addr; iram_wdata = wdata;
    #1;
    check({name, " addr_ok"}, {31'd0, iram_addr_ok}, {31'd0, exp_aok});
    @(posedge clk);
    #1;
    check({name, " data_ok"}, {31'd0, iram_data_ok}, {31'd0, exp_dok});
    if (chk_rd) check({name, " rdata"}, iram_rdata, exp_rd);
    $display("[TB] %-12s rst_b=%0b req=%0b wr=%0b addr=0x%08h -> data_ok=%0b rdata=0x%08h",
             name, rst, req, wr, addr, iram_data_ok, iram_rdata);
  endtask

  initial begin
    rst_b = 1'b0; iram_req = 1'b0; iram_write = 1'b0; iram_wstrb = 4'h0;
    iram_addr = '0; iram_wdata = '0;

    //            req wr  strb  addr          wdata         dok  rdata
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0011, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0004, 32'h0000_0022, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0008, 32'h0000_0033, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0011};
    vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_0022};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0008, 32'h0,         1'b1, 32'h0000_0033};
    vecs[6]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h0000_0033};
    vecs[7]  = '{1'b1, 1'b1, 4'h5, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0000_0033};
    vecs[8]  = '{1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h00AD_00EF};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 32'h00AD_00EF};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 1'b0, 4'h0, 32'h0000_4008, 32'h0,         1'b1, 32'h0000_0033};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 32'h0000_000B, 32'h0,         1'b1, 32'h0000_0033};
    vecs[14] = '{1'b1, 1'b1, 4'hF, 32'h0000_0014, 32'h1234_5678, 1'b1, 32'h0000_0033};
    vecs[15] = '{1'b1, 1'b1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 1'b1, 32'h0000_0033};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 32'h0000_0014, 32'h0,         1'b1, 32'h1234_5678};
    vecs[17] = '{1'b0, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset data_ok", {31'd0, iram_data_ok}, 32'd0);
    check("reset rdata", iram_rdata, 32'd0);

`ifndef IRAM_WAIT_STATE_EN
    for (int i = 0; i < 18; i++) begin
      step($sformatf("vec%0d", i), 1'b1, vecs[i].req, vecs[i].wr, vecs[i].strb, vecs[i].addr,
           vecs[i].wdata, 1'b1, vecs[i].exp_dok, 1'b1, vecs[i].exp_rdata);
    end

    // Reset while a read response is pending drops it
    step("rd_pend", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0011);
    step("rst_drop", 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0000);
    // Write presented during reset must not land
    step("rst_write", 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'hBAD0_BAD0, 1'b1, 1'b0, 1'b1, 32'h0);
    step("post_rst", 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    step("rd_after", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0011);
`else
    // Seed word 0 (stall, stall, accept), then read it with req held
    step("w_s0", 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0);
    step("w_s1", 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0);
    step("w_acc", 1'b1, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0000_0011, 1'b1, 1'b1, 1'b1, 32'h0);
    for (int r = 0; r < 2; r++) begin
      step("r_s0", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("r_s1", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("r_acc", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0011);
    end
    // Dropping req mid-wait restarts the stall
    step("d_s0", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("d_idle", 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("d_s0b", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("d_s1b", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("d_acc", 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0000_0011);
    step("d_end", 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_0011);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
